// File: rtl/regfile_pkg.sv
// Shared constants and packed-bus slicing helpers for the scoreboarded register file.
package regfile_pkg;

    localparam int DEF_DW   = 32;
    localparam int DEF_AW   = 5;
    localparam int ZERO_REG = 0;

    function automatic int ra_lsb(input int port, input int aw);
        return port * aw;
    endfunction

    function automatic int rd_lsb(input int port, input int dw);
        return port * dw;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits plus a registered popcount of them, for RAW hazard detection.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int AW = DEF_AW
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 IE,
    input  logic [AW-1:0]        IA,
    input  logic                 WE,
    input  logic [AW-1:0]        WA,
    output logic [(1<<AW)-1:0]   BUSY,
    output logic [AW-1:0]        BUSY_CNT
);

    localparam int DEPTH = 1 << AW;

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic [AW-1:0]    cnt_q;
    logic [AW-1:0]    cnt_d;
    logic             set_en;
    logic             clr_en;
    logic             inc;
    logic             dec;

    always_comb begin
        set_en = IE && (IA != AW'(ZERO_REG));
        clr_en = WE && (WA != AW'(ZERO_REG));

        // Clear first so a same-cycle issue to the same register wins.
        busy_d = busy_q;
        if (clr_en) busy_d[WA] = 1'b0;
        if (set_en) busy_d[IA] = 1'b1;
        busy_d[0] = 1'b0;

        inc = set_en && !busy_q[IA];
        dec = clr_en && busy_q[WA] && !(set_en && (IA == WA));

        cnt_d = cnt_q;
        if (inc && !dec)      cnt_d = cnt_q + AW'(1);
        else if (dec && !inc) cnt_d = cnt_q - AW'(1);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign BUSY     = busy_q;
    assign BUSY_CNT = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Parametrised multi-read-port register file (r0 hardwired to zero) with optional
// writeback bypass and an integrated busy scoreboard.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DW     = DEF_DW,
    parameter int AW     = DEF_AW,
    parameter int NR     = 2,
    parameter int BYPASS = 1
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [NR*AW-1:0]   RA,
    output logic [NR*DW-1:0]   RD,
    output logic [NR-1:0]      RBUSY,
    input  logic               WE,
    input  logic [AW-1:0]      WA,
    input  logic [DW-1:0]      WD,
    input  logic               IE,
    input  logic [AW-1:0]      IA,
    output logic [AW-1:0]      BUSY_CNT
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0]    mem_q [DEPTH];
    logic [DEPTH-1:0] busy;
    logic             wr_en;

    assign wr_en = WE && (WA != AW'(ZERO_REG));

    // Entry 0 is only ever cleared, so it reads as zero without special-casing storage.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[WA] <= WD;
        end
    end

    rf_scoreboard #(
        .AW (AW)
    ) u_scoreboard (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .IE       (IE),
        .IA       (IA),
        .WE       (WE),
        .WA       (WA),
        .BUSY     (busy),
        .BUSY_CNT (BUSY_CNT)
    );

    for (genvar gi = 0; gi < NR; gi++) begin : g_rport
        localparam int RA_LO = ra_lsb(gi, AW);
        localparam int RD_LO = rd_lsb(gi, DW);

        logic [AW-1:0] ra;
        logic [DW-1:0] rd;
        logic          rb;

        assign ra = RA[RA_LO +: AW];

        // Reset also masks the bypass path so outputs are zero while RST_N is low.
        always_comb begin
            rd = '0;
            rb = 1'b0;
            if (RST_N && (ra != AW'(ZERO_REG))) begin
                if ((BYPASS != 0) && WE && (WA == ra)) begin
                    rd = WD;
                end else begin
                    rd = mem_q[ra];
                    rb = busy[ra];
                end
            end
        end

        assign RD[RD_LO +: DW] = rd;
        assign RBUSY[gi]       = rb;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench: a BYPASS=1 and a BYPASS=0 instance share stimulus and are
// compared against directed vectors and an array-based reference model.
module tb_regfile_sb;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [9:0]  RA;
    logic        WE, IE;
    logic [4:0]  WA, IA;
    logic [31:0] WD;

    logic [63:0] rd_b, rd_n;
    logic [1:0]  rb_b, rb_n;
    logic [4:0]  cnt_b, cnt_n;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_data [32];
    bit          m_busy [32];

    always #5 CLK = ~CLK;

    regfile_sb #(.DW(32), .AW(5), .NR(2), .BYPASS(1)) u_byp (
        .CLK(CLK), .RST_N(RST_N), .RA(RA), .RD(rd_b), .RBUSY(rb_b),
        .WE(WE), .WA(WA), .WD(WD), .IE(IE), .IA(IA), .BUSY_CNT(cnt_b)
    );

    regfile_sb #(.DW(32), .AW(5), .NR(2), .BYPASS(0)) u_nob (
        .CLK(CLK), .RST_N(RST_N), .RA(RA), .RD(rd_n), .RBUSY(rb_n),
        .WE(WE), .WA(WA), .WD(WD), .IE(IE), .IA(IA), .BUSY_CNT(cnt_n)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 32'd0;
        if (byp && WE && (WA == a)) return WD;
        return m_data[a];
    endfunction

    function automatic logic exp_rb(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 1'b0;
        if (byp && WE && (WA == a)) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic logic [4:0] m_count();
        int n = 0;
        for (int r = 0; r < 32; r++) if (m_busy[r]) n++;
        return 5'(n);
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 32; r++) begin
            m_data[r] = '0;
            m_busy[r] = 1'b0;
        end
    endtask

    // Drive one cycle's inputs at the falling edge and check combinational reads.
    task automatic apply(input bit we, input logic [4:0] wa, input logic [31:0] wd,
                         input bit ie, input logic [4:0] ia,
                         input logic [4:0] ra0, input logic [4:0] ra1);
        logic [4:0] a;
        @(negedge CLK);
        WE = we; WA = wa; WD = wd; IE = ie; IA = ia; RA = {ra1, ra0};
        #1;
        for (int p = 0; p < 2; p++) begin
            a = (p == 0) ? ra0 : ra1;
            chk($sformatf("rd_byp p%0d a%0d", p, a), rd_b[p*32 +: 32], exp_rd(a, 1'b1));
            chk($sformatf("rd_nob p%0d a%0d", p, a), rd_n[p*32 +: 32], exp_rd(a, 1'b0));
            chk($sformatf("rbusy_byp p%0d a%0d", p, a), 32'(rb_b[p]), 32'(exp_rb(a, 1'b1)));
            chk($sformatf("rbusy_nob p%0d a%0d", p, a), 32'(rb_n[p]), 32'(exp_rb(a, 1'b0)));
        end
    endtask

    // Clock edge: update the model from the spec rules, then check the counter.
    task automatic edge_and_count();
        @(posedge CLK);
        if (WE && WA != 5'd0) begin
            m_data[WA] = WD;
            m_busy[WA] = 1'b0;
        end
        if (IE && IA != 5'd0) m_busy[IA] = 1'b1;
        #1;
        chk("busy_cnt_byp", 32'(cnt_b), 32'(m_count()));
        chk("busy_cnt_nob", 32'(cnt_n), 32'(m_count()));
    endtask

    typedef struct {
        bit          we;
        logic [4:0]  wa;
        logic [31:0] wd;
        bit          ie;
        logic [4:0]  ia;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] rd_n;
        bit          rb_n;
        logic [31:0] rd_b;
        bit          rb_b;
        logic [4:0]  cnt;
    } vec_t;

    vec_t tbl [13];

    initial begin
        RST_N = 1'b0;
        WE = 1'b0; WA = '0; WD = '0; IE = 1'b0; IA = '0; RA = '0;
        model_reset();

        //        we  wa     wd            ie  ia    ra0   ra1   rd_n          rb_n rd_b          rb_b cnt
        tbl[0]  = '{0, 5'd0, 32'h0,        0, 5'd0, 5'd0, 5'd1, 32'h0,        0,   32'h0,        0,   5'd0};
        tbl[1]  = '{0, 5'd0, 32'h0,        0, 5'd0, 5'd31,5'd0, 32'h0,        0,   32'h0,        0,   5'd0};
        tbl[2]  = '{1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 5'd5, 5'd5, 32'h0,        0,   32'hDEADBEEF, 0,   5'd0};
        tbl[3]  = '{0, 5'd0, 32'h0,        0, 5'd0, 5'd5, 5'd5, 32'hDEADBEEF, 0,   32'hDEADBEEF, 0,   5'd0};
        tbl[4]  = '{1, 5'd0, 32'h1234,     0, 5'd0, 5'd0, 5'd0, 32'h0,        0,   32'h0,        0,   5'd0};
        tbl[5]  = '{0, 5'd0, 32'h0,        0, 5'd0, 5'd0, 5'd5, 32'h0,        0,   32'h0,        0,   5'd0};
        tbl[6]  = '{0, 5'd0, 32'h0,        1, 5'd7, 5'd7, 5'd0, 32'h0,        0,   32'h0,        0,   5'd1};
        tbl[7]  = '{0, 5'd0, 32'h0,        1, 5'd7, 5'd7, 5'd0, 32'h0,        1,   32'h0,        1,   5'd1};
        tbl[8]  = '{1, 5'd7, 32'hA5A5A5A5, 0, 5'd0, 5'd7, 5'd7, 32'h0,        1,   32'hA5A5A5A5, 0,   5'd0};
        tbl[9]  = '{1, 5'd3, 32'h55,       1, 5'd3, 5'd3, 5'd0, 32'h0,        0,   32'h55,       0,   5'd1};
        tbl[10] = '{0, 5'd0, 32'h0,        0, 5'd0, 5'd3, 5'd7, 32'h55,       1,   32'h55,       1,   5'd1};
        tbl[11] = '{1, 5'd3, 32'h66,       1, 5'd4, 5'd3, 5'd4, 32'h55,       1,   32'h66,       0,   5'd1};
        tbl[12] = '{0, 5'd0, 32'h0,        0, 5'd0, 5'd4, 5'd3, 32'h0,        1,   32'h0,        1,   5'd1};

        // Outputs while held in reset.
        #3;
        chk("reset cnt_byp", 32'(cnt_b), 32'd0);
        chk("reset cnt_nob", 32'(cnt_n), 32'd0);
        chk("reset rd_byp", rd_b[31:0], 32'd0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;

        for (int i = 0; i < 13; i++) begin
            apply(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].ie, tbl[i].ia, tbl[i].ra0, tbl[i].ra1);
            chk($sformatf("vec%0d rd_nob", i), rd_n[31:0], tbl[i].rd_n);
            chk($sformatf("vec%0d rbusy_nob", i), 32'(rb_n[0]), 32'(tbl[i].rb_n));
            chk($sformatf("vec%0d rd_byp", i), rd_b[31:0], tbl[i].rd_b);
            chk($sformatf("vec%0d rbusy_byp", i), 32'(rb_b[0]), 32'(tbl[i].rb_b));
            edge_and_count();
            chk($sformatf("vec%0d cnt", i), 32'(cnt_b), 32'(tbl[i].cnt));
        end

        // Fill the scoreboard completely.
        for (int r = 1; r < 32; r++) begin
            apply(1'b0, 5'd0, 32'd0, 1'b1, 5'(r), 5'(r), 5'd0);
            edge_and_count();
        end
        chk("full cnt_byp", 32'(cnt_b), 32'd31);
        chk("full cnt_nob", 32'(cnt_n), 32'd31);

        // Asynchronous reset between edges, with a write pending on the bus.
        @(negedge CLK);
        #2;
        WE = 1'b1; WA = 5'd5; WD = 32'hFFFF_FFFF; IE = 1'b1; IA = 5'd2;
        RST_N = 1'b0;
        #1;
        model_reset();
        chk("async cnt_byp", 32'(cnt_b), 32'd0);
        chk("async cnt_nob", 32'(cnt_n), 32'd0);
        for (int a = 0; a < 32; a++) begin
            RA = {5'(31 - a), 5'(a)};
            #0.1;
            chk($sformatf("async rd_byp a%0d", a), rd_b[31:0], 32'd0);
            chk($sformatf("async rd_nob a%0d", a), rd_n[63:32], 32'd0);
            chk($sformatf("async rbusy a%0d", a), 32'({rb_b, rb_n}), 32'd0);
        end

        // Edge during reset is ignored.
        @(posedge CLK);
        #1;
        chk("in-reset cnt", 32'(cnt_b), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        WE = 1'b0; IE = 1'b0;
        RA = {5'd2, 5'd5};
        #1;
        chk("post-reset rd5", rd_n[31:0], 32'd0);
        chk("post-reset busy2", 32'(rb_n[1]), 32'd0);

        // First edge after release operates normally.
        apply(1'b1, 5'd6, 32'h0BAD_F00D, 1'b1, 5'd2, 5'd6, 5'd2);
        edge_and_count();
        apply(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd6, 5'd2);
        edge_and_count();

        // Randomised traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            logic [4:0] wa, ia, ra0, ra1;
            wa  = 5'($urandom_range(0, 31));
            ia  = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            ra0 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
            ra1 = ($urandom_range(0, 3) == 0) ? ia : 5'($urandom_range(0, 31));
            apply(1'($urandom_range(0, 1)), wa, $urandom, 1'($urandom_range(0, 1)), ia, ra0, ra1);
            edge_and_count();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
